// File: rtl/nd_router_1to2_if.sv
// Message channel bundle for the router: address, data and redundancy fields
// plus a 4-phase req/ack handshake. The sender of messages uses "master".
interface nd_router_1to2_if #(
  parameter int ASZ = 8,
  parameter int DSZ = 8,
  parameter int RSZ = 4
);
  logic [ASZ-1:0] addr;
  logic [DSZ-1:0] dat;
  logic [RSZ-1:0] red;
  logic           req;
  logic           ack;

  modport master (output addr, output dat, output red, output req, input ack);
  modport slave  (input addr, input dat, input red, input req, output ack);
endinterface

// File: rtl/nd_router_1to2.sv
// nd_router_1to2: takes messages off one 4-phase req/ack input channel and
// routes them to a local (snd0) or forward (snd1) output. Each output owns a
// one-message holding register so a blocked output never stalls the other.

// Level filter: the checked level follows the raw input only after the raw
// input has held the new level for CKS consecutive samples. The filtered
// output already reflects the sample that completes the run, so consumers
// react on the same edge.
module nd_router_1to2_dbnc #(
  parameter int CKS = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic ckd
);
  localparam int CW = $clog2(CKS + 1);

  logic [CW-1:0] cnt;
  logic          lvl;
  logic          done;

  assign done = (raw != lvl) && (cnt == CW'(CKS - 1));
  assign ckd  = done ? raw : lvl;

  // count how long the raw input has disagreed with the accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else if (raw == lvl) begin
      cnt <= '0;
    end else if (done) begin
      lvl <= raw;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module nd_router_1to2 #(
  parameter int             ASZ         = 8,
  parameter int             DSZ         = 8,
  parameter int             RSZ         = 4,
  parameter logic [ASZ-1:0] LOCAL_ADDR  = '0,
  parameter int             RCV_REQ_CKS = 3,
  parameter int             SND_ACK_CKS = 2
) (
  input  logic             gch_clk,
  input  logic             gch_reset,
  output logic             gch_ready,
  nd_router_1to2_if.slave  rcv0,
  nd_router_1to2_if.master snd0,
  nd_router_1to2_if.master snd1
);
  typedef enum logic {R_IDLE = 1'b0, R_ACK = 1'b1} rstate_t;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_REL = 2'd2} sstate_t;

  rstate_t        rstate, rstate_nx;
  sstate_t        sstate    [2];
  sstate_t        sstate_nx [2];
  logic [1:0]     full, accept, rel, ckd_ack;
  logic           ckd_req, tgt, ready;
  logic [ASZ-1:0] hold_addr [2];
  logic [DSZ-1:0] hold_dat  [2];
  logic [RSZ-1:0] hold_red  [2];

  nd_router_1to2_dbnc #(.CKS(RCV_REQ_CKS)) u_dbnc_req (
    .clk(gch_clk), .rst_n(gch_reset), .raw(rcv0.req), .ckd(ckd_req));
  nd_router_1to2_dbnc #(.CKS(SND_ACK_CKS)) u_dbnc_ack0 (
    .clk(gch_clk), .rst_n(gch_reset), .raw(snd0.ack), .ckd(ckd_ack[0]));
  nd_router_1to2_dbnc #(.CKS(SND_ACK_CKS)) u_dbnc_ack1 (
    .clk(gch_clk), .rst_n(gch_reset), .raw(snd1.ack), .ckd(ckd_ack[1]));

  // exact match on the full address selects local delivery; all else forwards
  assign tgt = (rcv0.addr == LOCAL_ADDR) ? 1'b0 : 1'b1;

  // input handshake: accept only into an empty target, release once req drops
  always_comb begin
    rstate_nx = rstate;
    accept    = 2'b00;
    case (rstate)
      R_IDLE: begin
        if (ckd_req && !full[tgt]) begin
          rstate_nx   = R_ACK;
          accept[tgt] = 1'b1;
        end else begin
          rstate_nx = R_IDLE;
        end
      end
      R_ACK: begin
        if (!ckd_req) rstate_nx = R_IDLE;
        else          rstate_nx = R_ACK;
      end
      default: rstate_nx = R_IDLE;
    endcase
  end

  // per-output handshake; an ack seen while idle is a protocol error and ignored
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sstate_nx[i] = sstate[i];
      rel[i]       = 1'b0;
      case (sstate[i])
        S_IDLE: begin
          if (full[i]) sstate_nx[i] = S_REQ;
          else         sstate_nx[i] = S_IDLE;
        end
        S_REQ: begin
          if (ckd_ack[i]) sstate_nx[i] = S_REL;
          else            sstate_nx[i] = S_REQ;
        end
        S_REL: begin
          if (!ckd_ack[i]) begin
            sstate_nx[i] = S_IDLE;
            rel[i]       = 1'b1;
          end else begin
            sstate_nx[i] = S_REL;
          end
        end
        default: sstate_nx[i] = S_IDLE;
      endcase
    end
  end

  // state registers and the ready flag
  always_ff @(posedge gch_clk or negedge gch_reset) begin
    if (!gch_reset) begin
      rstate <= R_IDLE;
      ready  <= 1'b0;
      for (int i = 0; i < 2; i++) sstate[i] <= S_IDLE;
    end else begin
      rstate <= rstate_nx;
      ready  <= 1'b1;
      for (int i = 0; i < 2; i++) sstate[i] <= sstate_nx[i];
    end
  end

  // holding registers: load on accept, free once the output handshake ends
  always_ff @(posedge gch_clk or negedge gch_reset) begin
    if (!gch_reset) begin
      full <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        hold_addr[i] <= '0;
        hold_dat[i]  <= '0;
        hold_red[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (accept[i]) begin
          full[i]      <= 1'b1;
          hold_addr[i] <= rcv0.addr;
          hold_dat[i]  <= rcv0.dat;
          hold_red[i]  <= rcv0.red;
        end else if (rel[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  assign gch_ready = ready;
  assign rcv0.ack  = (rstate == R_ACK);

  assign snd0.req  = (sstate[0] == S_REQ);
  assign snd0.addr = hold_addr[0];
  assign snd0.dat  = hold_dat[0];
  assign snd0.red  = hold_red[0];

  assign snd1.req  = (sstate[1] == S_REQ);
  assign snd1.addr = hold_addr[1];
  assign snd1.dat  = hold_dat[1];
  assign snd1.red  = hold_red[1];
endmodule

// File: tb/tb_nd_router_1to2.sv
// Bench for nd_router_1to2: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a transaction model.
module tb_nd_router_1to2;
  localparam int         ASZ     = 8;
  localparam int         DSZ     = 8;
  localparam int         RSZ     = 4;
  localparam logic [7:0] LOC     = 8'h3C;
  localparam int         RCV_CKS = 3;
  localparam int         SND_CKS = 2;

  typedef struct packed {
    logic       ckd;
    logic       prev;
    logic [7:0] run;
  } deb_t;

  typedef struct packed {
    logic           full;
    logic           req;
    logic           got;
    logic [ASZ-1:0] addr;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;
  } chan_t;

  typedef struct packed {
    deb_t  dreq;
    deb_t  dack0;
    deb_t  dack1;
    chan_t ch0;
    chan_t ch1;
    logic  ack;
    logic  ready;
  } model_t;

  logic   clk, rst_n, ready;
  model_t m;
  int     n_pass, n_total;
  int     rise0, rise1;
  logic   prev0, prev1;
  bit     rsp_en0, rsp_en1, rsp_rand;
  int     rsp_fix;

  nd_router_1to2_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) rcv ();
  nd_router_1to2_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) s0 ();
  nd_router_1to2_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) s1 ();

  nd_router_1to2 #(
    .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .LOCAL_ADDR(LOC),
    .RCV_REQ_CKS(RCV_CKS), .SND_ACK_CKS(SND_CKS)
  ) dut (
    .gch_clk(clk), .gch_reset(rst_n), .gch_ready(ready),
    .rcv0(rcv), .snd0(s0), .snd1(s1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, need %0h", name, act, exp);
  endtask

  // A level is believed once the last cks samples all agree on it.
  function automatic deb_t deb_step(deb_t d, logic raw, int cks);
    deb_t n = d;
    if (d.run != 8'd0 && raw == d.prev) n.run = (d.run == 8'hFF) ? d.run : d.run + 8'd1;
    else n.run = 8'd1;
    n.prev = raw;
    if (int'(n.run) >= cks) n.ckd = raw;
    return n;
  endfunction

  // Output side: request while holding a message, drop on ack, free on ack release.
  function automatic chan_t out_step(chan_t c, logic ack);
    chan_t n = c;
    if (!c.req && !c.got && c.full) n.req = 1'b1;
    else if (c.req && ack) begin n.req = 1'b0; n.got = 1'b1; end
    else if (c.got && !ack) begin n.got = 1'b0; n.full = 1'b0; end
    return n;
  endfunction

  function automatic model_t model_step(model_t mo);
    model_t n = mo;
    logic   to_local;
    n.ready = 1'b1;
    n.dreq  = deb_step(mo.dreq, rcv.req, RCV_CKS);
    n.dack0 = deb_step(mo.dack0, s0.ack, SND_CKS);
    n.dack1 = deb_step(mo.dack1, s1.ack, SND_CKS);
    n.ch0   = out_step(mo.ch0, n.dack0.ckd);
    n.ch1   = out_step(mo.ch1, n.dack1.ckd);
    to_local = (rcv.addr == LOC);
    if (!mo.ack) begin
      if (n.dreq.ckd && to_local && !mo.ch0.full) begin
        n.ack = 1'b1; n.ch0.full = 1'b1;
        n.ch0.addr = rcv.addr; n.ch0.dat = rcv.dat; n.ch0.red = rcv.red;
      end else if (n.dreq.ckd && !to_local && !mo.ch1.full) begin
        n.ack = 1'b1; n.ch1.full = 1'b1;
        n.ch1.addr = rcv.addr; n.ch1.dat = rcv.dat; n.ch1.red = rcv.red;
      end
    end else if (!n.dreq.ckd) begin
      n.ack = 1'b0;
    end
    return n;
  endfunction

  // reference model advances once per clock, cleared by the same async reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_step(m);
  end

  // compare every DUT output with the model each cycle; count request rises
  always @(negedge clk) begin
    check("ctl", 64'({ready, rcv.ack, s0.req, s1.req}), 64'({m.ready, m.ack, m.ch0.req, m.ch1.req}));
    check("msg0", 64'({s0.addr, s0.dat, s0.red}), 64'({m.ch0.addr, m.ch0.dat, m.ch0.red}));
    check("msg1", 64'({s1.addr, s1.dat, s1.red}), 64'({m.ch1.addr, m.ch1.dat, m.ch1.red}));
    rise0 <= rise0 + ((s0.req && !prev0) ? 1 : 0);
    rise1 <= rise1 + ((s1.req && !prev1) ? 1 : 0);
    prev0 <= s0.req;
    prev1 <= s1.req;
  end

  function automatic int rsp_dly();
    return rsp_rand ? int'($urandom_range(0, 4)) : rsp_fix;
  endfunction

  // local-output consumer
  initial begin
    s0.ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rsp_en0 && s0.req) begin
        repeat (rsp_dly()) begin @(posedge clk); #1; end
        s0.ack = 1'b1;
        for (int k = 0; k < 40 && s0.req; k++) begin @(posedge clk); #1; end
        repeat (rsp_dly()) begin @(posedge clk); #1; end
        s0.ack = 1'b0;
      end
    end
  end

  // forward-output consumer
  initial begin
    s1.ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rsp_en1 && s1.req) begin
        repeat (rsp_dly()) begin @(posedge clk); #1; end
        s1.ack = 1'b1;
        for (int k = 0; k < 40 && s1.req; k++) begin @(posedge clk); #1; end
        repeat (rsp_dly()) begin @(posedge clk); #1; end
        s1.ack = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_req(input int ch, input logic lvl, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (((ch == 0) ? s0.req : s1.req) == lvl) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic drop_req();
    rcv.req = 1'b0;
    for (int k = 0; k < 20 && rcv.ack; k++) tick();
  endtask

  task automatic send(input logic [ASZ-1:0] a, input logic [DSZ-1:0] d,
                      input logic [RSZ-1:0] r, output int lat);
    rcv.addr = a; rcv.dat = d; rcv.red = r; rcv.req = 1'b1;
    lat = -1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (rcv.ack) begin lat = k; break; end
    end
    drop_req();
  endtask

  initial begin
    int          lat, r0, r1, n_loc, n_fwd;
    bit          ok, seen;
    logic [7:0]  a, d;
    logic [3:0]  r;
    n_pass = 0; n_total = 0; rise0 = 0; rise1 = 0; prev0 = 1'b0; prev1 = 1'b0;
    rsp_en0 = 1'b0; rsp_en1 = 1'b0; rsp_rand = 1'b0; rsp_fix = 0;
    rst_n = 1'b0;
    rcv.addr = '0; rcv.dat = '0; rcv.red = '0; rcv.req = 1'b0;

    // 1: reset held for 5 cycles, ready one edge after release
    repeat (3) tick();
    check("t1_rst_ctl", 64'({ready, rcv.ack, s0.req, s1.req}), 64'd0);
    check("t1_rst_msg", 64'({s0.addr, s0.dat, s0.red, s1.addr, s1.dat, s1.red}), 64'd0);
    repeat (2) tick();
    @(negedge clk); rst_n = 1'b1; #1;
    check("t1_ready_before_edge", 64'(ready), 64'd0);
    tick();
    check("t1_ready_after_edge", 64'(ready), 64'd1);
    repeat (2) tick();

    // 2: local message, snd0 acks after 3 cycles
    r1 = rise1;
    rsp_fix = 3; rsp_en0 = 1'b1; rsp_en1 = 1'b1;
    rcv.addr = LOC; rcv.dat = 8'h5A; rcv.red = 4'h6; rcv.req = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (rcv.ack) begin lat = k; break; end
    end
    check("t2_req_to_ack", 64'(lat), 64'd3);
    tick();
    check("t2_snd0_req_1cyc", 64'(s0.req), 64'd1);
    check("t2_snd0_msg", 64'({s0.addr, s0.dat, s0.red}), 64'({8'h3C, 8'h5A, 4'h6}));
    check("t2_model_pin", 64'(m.ch0.dat), 64'h5A);
    drop_req();
    wait_req(0, 1'b0, ok);
    check("t2_snd0_done", 64'(ok), 64'd1);
    repeat (8) tick();
    check("t2_snd1_quiet", 64'(rise1 - r1), 64'd0);

    // 3: forwarded message, redundancy passes through bit-exact
    r0 = rise0;
    rsp_fix = 2;
    send(LOC + 8'd1, 8'hC3, 4'hA, lat);
    check("t3_accept", 64'(lat), 64'd3);
    wait_req(1, 1'b1, ok);
    check("t3_snd1_msg", 64'({s1.addr, s1.dat, s1.red}), 64'({8'h3D, 8'hC3, 4'hA}));
    wait_req(1, 1'b0, ok);
    check("t3_snd1_done", 64'(ok), 64'd1);
    repeat (8) tick();
    check("t3_snd0_quiet", 64'(rise0 - r0), 64'd0);

    // 4: blocked local output holds A, B still forwarded, C stalls the input
    rsp_en0 = 1'b0;
    send(LOC, 8'hA1, 4'h1, lat);
    check("t4_accept_a", 64'(lat), 64'd3);
    send(8'h77, 8'hB2, 4'h2, lat);
    check("t4_accept_b", 64'(lat), 64'd3);
    wait_req(1, 1'b1, ok);
    check("t4_snd1_b", 64'({s1.addr, s1.dat, s1.red}), 64'({8'h77, 8'hB2, 4'h2}));
    wait_req(1, 1'b0, ok);
    rcv.addr = LOC; rcv.dat = 8'hC4; rcv.red = 4'h3; rcv.req = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin tick(); seen = seen | rcv.ack; end
    check("t4_c_stalled", 64'(seen), 64'd0);
    check("t4_snd0_holds_a", 64'({s0.req, s0.addr, s0.dat, s0.red}), 64'({1'b1, 8'h3C, 8'hA1, 4'h1}));
    rsp_fix = 0; rsp_en0 = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (rcv.ack) begin lat = k; break; end
    end
    check("t4_c_accepted", 64'(lat > 0), 64'd1);
    drop_req();
    wait_req(0, 1'b1, ok);
    check("t4_snd0_c", 64'({s0.addr, s0.dat, s0.red}), 64'({8'h3C, 8'hC4, 4'h3}));
    wait_req(0, 1'b0, ok);
    repeat (8) tick();

    // 5: request glitch one cycle shorter than the filter length
    r0 = rise0; r1 = rise1;
    rcv.addr = LOC; rcv.req = 1'b1;
    repeat (RCV_CKS - 1) tick();
    rcv.req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin tick(); seen = seen | rcv.ack | s0.req | s1.req; end
    check("t5_glitch_ignored", 64'({seen, 8'(rise0 - r0), 8'(rise1 - r1)}), 64'd0);

    // 6: reset while snd1 is requesting, then a clean transfer
    rsp_en1 = 1'b0;
    send(8'h10, 8'h66, 4'h9, lat);
    wait_req(1, 1'b1, ok);
    check("t6_snd1_req", 64'(ok), 64'd1);
    #2 rst_n = 1'b0; #1;
    check("t6_rst_drops", 64'({s1.req, rcv.ack, ready}), 64'd0);
    repeat (3) tick();
    @(negedge clk); rst_n = 1'b1;
    repeat (2) tick();
    rsp_fix = 1;
    send(LOC, 8'h99, 4'h5, lat);
    check("t6_accept_after", 64'(lat), 64'd3);
    wait_req(0, 1'b1, ok);
    check("t6_snd0_msg", 64'({s0.addr, s0.dat, s0.red}), 64'({8'h3C, 8'h99, 4'h5}));
    wait_req(0, 1'b0, ok);
    repeat (8) tick();

    // randomized traffic with random consumers and occasional request glitches
    rsp_rand = 1'b1; rsp_en0 = 1'b1; rsp_en1 = 1'b1;
    r0 = rise0; r1 = rise1; n_loc = 0; n_fwd = 0;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 2))
        0:       a = LOC;
        1:       a = LOC + 8'd1;
        default: a = 8'($urandom);
      endcase
      d = 8'($urandom); r = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        rcv.addr = 8'($urandom); rcv.req = 1'b1;
        repeat ($urandom_range(1, RCV_CKS - 1)) tick();
        rcv.req = 1'b0;
        tick();
      end
      send(a, d, r, lat);
      check("rnd_accept", 64'(lat > 0), 64'd1);
      if (a == LOC) n_loc++;
      else          n_fwd++;
      repeat ($urandom_range(0, 3)) tick();
    end
    for (int k = 0; k < 200 && (m.ch0.full || m.ch1.full || m.ack); k++) tick();
    repeat (2) tick();
    check("rnd_local_count", 64'(rise0 - r0), 64'(n_loc));
    check("rnd_fwd_count", 64'(rise1 - r1), 64'(n_fwd));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
